memoria_dados: RTL

- Data-memory responder for the control unit's memory signals MemEn, MemOp and Clear.
- Sits beside the register file and services three operations: memory read (opcode 110), memory write (111) and memory clear (100).
- Read and write each complete in one cycle.
- Clear is a multi-cycle sweep that zeroes every word. During the sweep the block raises Ocupado, and the datapath stalls instruction issue until Ocupado drops.

---
 rtl/memoria_dados_pkg.sv | 13 +
 rtl/memoria_dados_contador_limpeza.sv | 32 +++
 rtl/memoria_dados.sv | 97 +++++++++
 3 files changed

// File: rtl/memoria_dados_pkg.sv
// Shared definitions for the data memory: controller state encoding and default widths.
// The control unit and the datapath import the same widths from here.
package memoria_dados_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    OCIOSO  = 1'b0,
    LIMPEZA = 1'b1
  } estado_t;

endpackage

// File: rtl/memoria_dados_contador_limpeza.sv
// Sweep address counter for the clear operation.
// It supports clear and enable inputs and flags the last word.
module contador_limpeza #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] contagem,
  output logic              fim
);

  logic [ADDR_W-1:0] contagem_q, contagem_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    contagem_d = contagem_q;
    if (clr)     contagem_d = '0;
    else if (en) contagem_d = contagem_q + 1'b1;  // wraps to 0 after the last word
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) contagem_q <= '0;
    else     contagem_q <= contagem_d;
  end

  assign contagem = contagem_q;
  assign fim      = (contagem_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/memoria_dados.sv
// Data-memory responder: single-cycle read/write plus a multi-cycle clear sweep.
// Ocupado is high during the sweep, and requests made then are ignored.
module memoria_dados
  import memoria_dados_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemEn,
  input  logic              MemOp,
  input  logic              Clear,
  input  logic [ADDR_W-1:0] Endereco,
  input  logic [DATA_W-1:0] DadoEscrita,
  output logic [DATA_W-1:0] DadoLeitura,
  output logic              Pronto,
  output logic              Ocupado
);

  localparam int DEPTH = 1 << ADDR_W;

  estado_t           estado_q, estado_d;
  logic [DATA_W-1:0] dado_leitura_q, dado_leitura_d;
  logic              pronto_q, pronto_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aceita, inicia_limpeza, escrita, leitura, varrendo;
  logic [ADDR_W-1:0] contador;
  logic              contador_fim;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    aceita         = (estado_q == OCIOSO) && MemEn;
    inicia_limpeza = aceita && Clear;
    escrita        = aceita && !Clear && MemOp;
    leitura        = aceita && !Clear && !MemOp;
    varrendo       = (estado_q == LIMPEZA);

    estado_d       = estado_q;
    dado_leitura_d = dado_leitura_q;
    pronto_d       = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (inicia_limpeza) estado_d = LIMPEZA;
        if (leitura) dado_leitura_d = mem[Endereco];
        pronto_d = escrita || leitura;
      end
      LIMPEZA: begin
        if (contador_fim) begin
          estado_d = OCIOSO;
          pronto_d = 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // The sweep and CPU writes share one write port; the sweep owns it while busy.
    mem_we    = !rst && (escrita || varrendo);
    mem_addr  = varrendo ? contador : Endereco;
    mem_wdata = varrendo ? '0 : DadoEscrita;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q       <= OCIOSO;
      dado_leitura_q <= '0;
      pronto_q       <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      dado_leitura_q <= dado_leitura_d;
      pronto_q       <= pronto_d;
    end
  end

  // NOTE: the storage array has no reset; an aborted sweep must leave the words it has not reached untouched.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  contador_limpeza #(.ADDR_W(ADDR_W)) u_contador (
    .clk      (clk),
    .rst      (rst),
    .clr      (inicia_limpeza),
    .en       (varrendo),
    .contagem (contador),
    .fim      (contador_fim)
  );

  assign DadoLeitura = dado_leitura_q;
  assign Pronto      = pronto_q;
  assign Ocupado     = (estado_q == LIMPEZA);

endmodule
